// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring subtract-shift
// step per cycle, with sign and special-case fix-up in a final cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [2:0]       i_func,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;
    logic             r_busy;
    logic             r_done;
    logic [CW-1:0]    r_count;
    logic [2:0]       r_func;
    logic             r_sign_a;
    logic             r_sign_b;
    logic             r_b_zero;
    logic             r_ovf;
    logic [WIDTH-1:0] r_opnd;   // multiplicand (mul) or divisor (div)
    logic [WIDTH-1:0] r_hi;     // product high half / partial remainder
    logic [WIDTH-1:0] r_lo;     // multiplier / dividend, becomes product low half / quotient
    logic [WIDTH-1:0] r_result;

    // ---------------- operand preparation ----------------
    logic             w_is_div;
    logic             w_a_signed;
    logic             w_b_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    always_comb begin
        w_is_div   = i_func[2];
        w_a_signed = (i_func == 3'b001) || (i_func == 3'b010) ||
                     (i_func == 3'b100) || (i_func == 3'b110);
        w_b_signed = (i_func == 3'b001) || (i_func == 3'b100) || (i_func == 3'b110);
        w_a_neg    = w_a_signed & i_op_a[WIDTH-1];
        w_b_neg    = w_b_signed & i_op_b[WIDTH-1];
        w_a_mag    = w_a_neg ? -i_op_a : i_op_a;
        w_b_mag    = w_b_neg ? -i_op_b : i_op_b;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == S_ITER) || (w_state_next == S_FIX);
            r_done  <= (w_state_next == S_DONE);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_ITER;
                end
            end
            S_ITER: begin
                if (r_count == LAST_STEP) w_state_next = S_FIX;
            end
            S_FIX:  w_state_next = S_DONE;
            S_DONE: begin
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_ITER;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- iteration step ----------------
    logic [WIDTH:0]   w_madd;
    logic [WIDTH:0]   w_dshift;
    logic [WIDTH-1:0] w_ddiff;
    logic             w_dge;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    always_comb begin
        w_madd     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
        w_dshift   = {r_hi, r_lo[WIDTH-1]};
        w_dge      = (w_dshift >= {1'b0, r_opnd});
        // Low bits suffice: when the subtraction is taken the difference is below the divisor.
        w_ddiff    = w_dshift[WIDTH-1:0] - r_opnd;
        w_rem_next = w_dge ? w_ddiff : w_dshift[WIDTH-1:0];
        w_quo_next = {r_lo[WIDTH-2:0], w_dge};
    end

    // ---------------- sign and special-case fix-up ----------------
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_quo_s;
    logic [WIDTH-1:0]   w_rem_s;
    logic [WIDTH-1:0]   w_fix_result;

    always_comb begin
        w_prod   = {r_hi, r_lo};
        w_prod_s = (r_sign_a ^ r_sign_b) ? -w_prod : w_prod;
        w_quo_s  = (r_sign_a ^ r_sign_b) ? -r_lo : r_lo;
        w_rem_s  = r_sign_a ? -r_hi : r_hi;
        case (r_func)
            3'b000:                 w_fix_result = w_prod_s[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: w_fix_result = w_prod_s[2*WIDTH-1:WIDTH];
            3'b100, 3'b101: begin
                if (r_b_zero)   w_fix_result = {WIDTH{1'b1}};
                else if (r_ovf) w_fix_result = MIN_NEG;
                else            w_fix_result = w_quo_s;
            end
            default: begin
                // Divide-by-zero leaves |opA| in the remainder, so re-signing yields opA.
                if (r_ovf) w_fix_result = {WIDTH{1'b0}};
                else       w_fix_result = w_rem_s;
            end
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count  <= '0;
            r_func   <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_b_zero <= 1'b0;
            r_ovf    <= 1'b0;
            r_opnd   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_count  <= '0;
            r_func   <= i_func;
            r_sign_a <= w_a_neg;
            r_sign_b <= w_b_neg;
            r_b_zero <= (i_op_b == '0);
            r_ovf    <= ((i_func == 3'b100) || (i_func == 3'b110)) &&
                        (i_op_a == MIN_NEG) && (i_op_b == {WIDTH{1'b1}});
            r_opnd   <= w_is_div ? w_b_mag : w_a_mag;
            r_lo     <= w_is_div ? w_a_mag : w_b_mag;
            r_hi     <= '0;
        end else if (r_state == S_ITER) begin
            r_count <= r_count + 1'b1;
            if (r_func[2]) begin
                r_hi <= w_rem_next;
                r_lo <= w_quo_next;
            end else begin
                r_hi <= w_madd[WIDTH:1];
                r_lo <= {w_madd[0], r_lo[WIDTH-1:1]};
            end
        end else if (r_state == S_FIX) begin
            r_result <= w_fix_result;
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, handshake and
// reset sequences, and a biased random regression against a reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  func;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_func   (func),
        .i_op_a   (op_a),
        .i_op_b   (op_b),
        .o_busy   (busy),
        .o_done   (done),
        .o_result (result)
    );

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[20];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_exp = 32'h0;
    string       cur_name = "reset";

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sp;
        logic [63:0]        up;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (f)
            3'd0: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * $signed({32'b0, b}); return sp[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFFFFFF;
                sp = sa / sb;
                return sp[31:0];
            end
            3'd5: return (b == 32'h0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 32'h0) return a;
                sp = sa % sb;
                return sp[31:0];
            end
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 9))
            0:       return 32'h0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (done && busy) begin
                n_err++;
                $display("FAIL %s busy_done_overlap: busy=%b done=%b, required not both", cur_name, busy, done);
            end
            if (done) begin
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL %s unexpected_done: result=%h, required no done", cur_name, result);
                end else begin
                    chk({cur_name, " result"}, result, sb_q.pop_front());
                end
            end
        end
    end

    // Drives one operation after `gap` idle negedges; returns at the negedge of its DONE cycle.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int glitch_at, input int gap);
        int lat;
        bit busy_ok;
        repeat (gap) @(negedge clk);
        if (gap > 0) chk({cur_name, " held_result"}, result, last_exp);
        func  = f;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        sb_q.push_back(exp);
        @(posedge clk);
        lat     = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) start = 1'b0;
            if (glitch_at > 0 && lat == glitch_at) begin
                start = 1'b1;
                func  = ~f;
                op_a  = ~a;
                op_b  = b ^ 32'h5;
            end
            if (glitch_at > 0 && lat == glitch_at + 1) start = 1'b0;
            if (!done && !busy) busy_ok = 1'b0;
        end while (!done && lat < 60);
        chk({cur_name, " latency"}, 32'(lat), 32'd34);
        chk({cur_name, " busy_window"}, {31'b0, busy_ok}, 32'd1);
        last_exp = exp;
    endtask

    initial begin
        int  lat;
        bit  saw_done;
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;

        rst = 1'b1; start = 1'b0; func = 3'd0; op_a = 32'h0; op_b = 32'h0;

        vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
        vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000};
        vecs[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
        vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
        vecs[6]  = '{3'd5, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC};
        vecs[7]  = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF};
        vecs[8]  = '{3'd7, 32'd5,        32'd0,        32'd5};
        vecs[9]  = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        vecs[10] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0};
        vecs[11] = '{3'd0, 32'h12345678, 32'h10,       32'h23456780};
        vecs[12] = '{3'd1, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF};
        vecs[13] = '{3'd3, 32'h80000000, 32'd2,        32'd1};
        vecs[14] = '{3'd4, 32'd7,        32'd0,        32'hFFFFFFFF};
        vecs[15] = '{3'd6, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9};
        vecs[16] = '{3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD};
        vecs[17] = '{3'd6, 32'd7,        32'hFFFFFFFE, 32'd1};
        vecs[18] = '{3'd5, 32'd100,      32'd7,        32'd14};
        vecs[19] = '{3'd7, 32'd100,      32'd7,        32'd2};

        repeat (3) @(negedge clk);
        chk("reset busy",   {31'b0, busy}, 32'd0);
        chk("reset done",   {31'b0, done}, 32'd0);
        chk("reset result", result,        32'd0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            cur_name = $sformatf("vec%0d", i);
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, 0, 1);
        end

        // A start pulse mid-operation must not disturb the running op.
        cur_name = "glitch_start";
        run_op(3'd0, 32'h1234, 32'h10, 32'h12340, 10, 1);

        // start held in the DONE cycle launches the next op immediately.
        cur_name = "b2b_first";
        run_op(3'd4, 32'd1000, 32'd7, 32'd142, 0, 2);
        cur_name = "b2b_second";
        run_op(3'd6, 32'd1000, 32'd7, 32'd6, 0, 0);

        // Reset at cycle 15 of a divide.
        cur_name = "reset_mid_op";
        @(negedge clk);
        func = 3'd4; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
        sb_q.push_back(32'd14);
        @(posedge clk);
        for (lat = 1; lat <= 15; lat++) begin
            @(negedge clk);
            if (lat == 1) start = 1'b0;
        end
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        chk("reset_mid_op busy",   {31'b0, busy}, 32'd0);
        chk("reset_mid_op done",   {31'b0, done}, 32'd0);
        chk("reset_mid_op result", result,        32'd0);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("reset_mid_op no_done", {31'b0, saw_done}, 32'd0);
        last_exp = 32'h0;
        cur_name = "after_reset";
        run_op(3'd4, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 0, 1);

        for (int i = 0; i < 1200; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = pick_operand();
            rb = pick_operand();
            cur_name = $sformatf("rand%0d f=%0d a=%h b=%h", i, rf, ra, rb);
            run_op(rf, ra, rb, ref_model(rf, ra, rb), 0, $urandom_range(0, 2));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
